// File: rtl/burst_main_memory.sv
// Byte-addressed, big-endian main memory with single-word and 4/8/16-word bursts.
// Busy, read data and the out-of-range pulse are all registered.
module burst_main_memory #(
  parameter int unsigned                data_width    = 32,
  parameter int unsigned                address_width = 32,
  parameter int unsigned                depth         = 1048576,
  parameter logic [address_width-1:0]   start_addr    = 32'h80020000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    data_in,
  input  logic [1:0]               access_size,
  input  logic                     rw,
  input  logic                     enable,
  output logic                     busy,
  output logic [data_width-1:0]    data_out,
  output logic                     addr_error
);

  localparam int unsigned WORDS = depth / 4;
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned AW1   = address_width + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [AW1-1:0]          r_addr;
  logic                    r_rw;
  logic [3:0]              r_remaining;
  logic [3:0]              w_remaining_next;
  logic [3:0]              w_len;
  logic                    w_beat_valid;
  logic                    w_beat_rw;
  logic [AW1-1:0]          w_beat_addr;
  logic [address_width-1:0] w_off;
  logic                    w_in_range;
  logic [IDX_W-1:0]        w_idx;
  logic [data_width-1:0]   r_mem [WORDS];

  // Beats remaining after beat 0 for each burst length code.
  always_comb begin
    w_len = 4'd0;
    case (access_size)
      2'b00:   w_len = 4'd0;
      2'b01:   w_len = 4'd3;
      2'b10:   w_len = 4'd7;
      default: w_len = 4'd15;
    endcase
  end

  // Next state and the address/direction of the beat executing at this edge.
  always_comb begin
    w_next_state     = r_state;
    w_remaining_next = r_remaining;
    w_beat_valid     = 1'b0;
    w_beat_rw        = r_rw;
    w_beat_addr      = r_addr;
    case (r_state)
      S_IDLE: begin
        w_beat_rw   = rw;
        w_beat_addr = {1'b0, address & ~address_width'(3)};
        if (enable) begin
          w_beat_valid     = 1'b1;
          w_remaining_next = w_len;
          if (w_len != 4'd0) w_next_state = S_BURST;
        end
      end
      S_BURST: begin
        w_beat_valid     = 1'b1;
        w_remaining_next = r_remaining - 4'd1;
        if (r_remaining == 4'd1) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The top address bit records a carry past 2^32, which is always out of range.
  assign w_off      = w_beat_addr[address_width-1:0] - start_addr;
  assign w_in_range = !w_beat_addr[address_width] &&
                      (w_beat_addr[address_width-1:0] >= start_addr) &&
                      (({1'b0, w_off} + AW1'(3)) < AW1'(depth));
  assign w_idx      = IDX_W'(w_off >> 2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 4'd0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
      addr_error  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_remaining_next;
      busy        <= (w_next_state == S_BURST);
      addr_error  <= w_beat_valid && !w_in_range;
      if (w_beat_valid && w_beat_rw)
        data_out <= w_in_range ? r_mem[w_idx] : '0;
      if (r_state == S_IDLE && enable) begin
        r_rw   <= rw;
        r_addr <= w_beat_addr + AW1'(4);
      end else if (r_state == S_BURST) begin
        r_addr <= r_addr + AW1'(4);
      end
    end
  end

  // Word storage; aligned words map big-endian so the lowest byte sits in the MSBs.
  always_ff @(posedge clock) begin
    if (!reset && w_beat_valid && !w_beat_rw && w_in_range)
      r_mem[w_idx] <= data_in;
  end

endmodule

// File: tb/tb_burst_main_memory.sv
// Self-checking bench for burst_main_memory: transaction-level memory model plus
// literal expectations for the directed scenarios.
module tb_burst_main_memory;

  localparam logic [31:0] START = 32'h80020000;
  localparam longint      DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        addr_error;

  burst_main_memory dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .access_size (access_size),
    .rw          (rw),
    .enable      (enable),
    .busy        (busy),
    .data_out    (data_out),
    .addr_error  (addr_error)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_en = 0;
  logic        exp_busy = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_dout = '0;
  bit          exp_known = 1'b1;
  bit [31:0]   mdl [longint];
  int          busy_cnt;
  int          err_cnt;
  logic [31:0] rd_log [$];

  // Cycle-by-cycle comparison against the model's expectations.
  always @(negedge clock) begin
    if (chk_en) begin
      n_cmp++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy @%0t: got %b want %b", $time, busy, exp_busy);
      end
      n_cmp++;
      if (addr_error !== exp_err) begin
        n_fail++;
        $display("FAIL addr_error @%0t: got %b want %b", $time, addr_error, exp_err);
      end
      if (exp_known) begin
        n_cmp++;
        if (data_out !== exp_dout) begin
          n_fail++;
          $display("FAIL data_out @%0t: got %h want %h", $time, data_out, exp_dout);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Effect of beat i of an n-beat burst, from address range rules alone.
  task automatic model_beat(input logic [31:0] base, input int i, input bit is_rd,
                            input logic [31:0] wd, input int n);
    longint a;
    bit     oor;
    a   = longint'(base) + longint'(4 * i);
    oor = (a >= 64'sh1_0000_0000) || (a < longint'(START)) ||
          (a - longint'(START) + 3 >= DEPTH);
    exp_busy = (i < n - 1);
    exp_err  = oor;
    if (is_rd) begin
      if (oor) begin
        exp_dout  = '0;
        exp_known = 1'b1;
      end else if (mdl.exists(a - longint'(START))) begin
        exp_dout  = mdl[a - longint'(START)];
        exp_known = 1'b1;
      end else begin
        exp_known = 1'b0;
      end
    end else if (!oor) begin
      mdl[a - longint'(START)] = wd;
    end
  endtask

  // One request; beats after the first drive junk on ignored inputs. abort_at >= 0 resets at that beat.
  task automatic run_req(input logic [31:0] addr, input logic [1:0] sz, input bit is_rd,
                         input logic [31:0] seed, input int abort_at);
    int          n;
    logic [31:0] wd;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
    busy_cnt = 0;
    err_cnt  = 0;
    rd_log.delete();
    for (int i = 0; i < n; i++) begin
      wd      = seed + 32'h11111111 * 32'(i);
      data_in = wd;
      if (i == abort_at) begin
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clock);
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        exp_dout  = '0;
        exp_known = 1'b1;
        #1;
        reset = 1'b0;
        return;
      end
      enable = 1'b1;
      if (i == 0) begin
        address     = addr;
        rw          = is_rd;
        access_size = sz;
      end else begin
        address     = $urandom;
        rw          = ~is_rd;
        access_size = 2'($urandom);
      end
      @(posedge clock);
      model_beat(addr & ~32'd3, i, is_rd, wd, n);
      #1;
      if (busy) busy_cnt++;
      if (addr_error) err_cnt++;
      rd_log.push_back(data_out);
    end
    enable = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    address     = '0;
    data_in     = '0;
    access_size = 2'd0;
    rw          = 1'b0;
    @(posedge clock);
    chk_en = 1'b1;
    @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset data_out", data_out, 32'h0);
    check("reset addr_error", 32'(addr_error), 32'd0);
    reset = 1'b0;

    // Single write then read
    run_req(START, 2'd0, 1'b0, 32'h27BDFFF8, -1);
    check("single write busy cycles", 32'(busy_cnt), 32'd0);
    run_req(START, 2'd0, 1'b1, 32'h0, -1);
    check("single read data", rd_log[0], 32'h27BDFFF8);
    check("lowest byte in msb", 32'(rd_log[0][31:24]), 32'h27);
    check("single read busy cycles", 32'(busy_cnt), 32'd0);

    // 4-word burst write then read
    run_req(START + 32'h10, 2'd1, 1'b0, 32'h11111111, -1);
    check("burst4 write busy cycles", 32'(busy_cnt), 32'd3);
    run_req(START + 32'h10, 2'd1, 1'b1, 32'h0, -1);
    check("burst4 read busy cycles", 32'(busy_cnt), 32'd3);
    check("burst4 beat0", rd_log[0], 32'h11111111);
    check("burst4 beat1", rd_log[1], 32'h22222222);
    check("burst4 beat2", rd_log[2], 32'h33333333);
    check("burst4 beat3", rd_log[3], 32'h44444444);

    // Bursts that run off the top of memory
    run_req(START + 32'(DEPTH) - 32'd8, 2'd1, 1'b0, 32'hA0A0A0A0, -1);
    check("edge write errors", 32'(err_cnt), 32'd2);
    run_req(START + 32'(DEPTH) - 32'd8, 2'd3, 1'b1, 32'h0, -1);
    check("burst16 busy cycles", 32'(busy_cnt), 32'd15);
    check("burst16 errors", 32'(err_cnt), 32'd14);
    check("burst16 beat0", rd_log[0], 32'hA0A0A0A0);
    check("burst16 beat1", rd_log[1], 32'hB1B1B1B1);
    check("burst16 beat2", rd_log[2], 32'h0);
    check("burst16 beat15", rd_log[15], 32'h0);

    // Below start_addr, unaligned address, and 32-bit wrap
    run_req(32'h80010000, 2'd0, 1'b1, 32'h0, -1);
    check("below start error", 32'(err_cnt), 32'd1);
    check("below start data", rd_log[0], 32'h0);
    run_req(32'h80020003, 2'd0, 1'b0, 32'hCAFEF00D, -1);
    check("unaligned write error", 32'(err_cnt), 32'd0);
    run_req(START, 2'd0, 1'b1, 32'h0, -1);
    check("unaligned maps to base", rd_log[0], 32'hCAFEF00D);
    run_req(32'hFFFFFFF8, 2'd1, 1'b1, 32'h0, -1);
    check("wrap burst errors", 32'(err_cnt), 32'd4);

    // Reset in the middle of an 8-word write burst
    run_req(START + 32'h100, 2'd2, 1'b0, 32'h01010101, -1);
    run_req(START + 32'h100, 2'd2, 1'b0, 32'h90000000, 3);
    run_req(START + 32'h100, 2'd2, 1'b1, 32'h0, -1);
    check("abort word0", rd_log[0], 32'h90000000);
    check("abort word2", rd_log[2], 32'hB2222222);
    check("abort word3 untouched", rd_log[3], 32'h34343434);
    check("abort word7 untouched", rd_log[7], 32'h78787878);
    check("post-abort busy cycles", 32'(busy_cnt), 32'd7);

    repeat (3) begin
      address = $urandom;
      @(posedge clock);
      exp_busy = 1'b0;
      exp_err  = 1'b0;
      #1;
    end
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
